// File: rtl/sram_req_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sram_req_arbiter_pkg
// Shared constants for the sram-like request arbiter:
//   - source IDs stored in the outstanding-transaction FIFO
//   - arbiter state encoding
//   - width of the packed request field bundle {wr, size, wstrb, addr, wdata}
// ----------------------------------------------------------------------------
package sram_req_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    localparam logic [0:0] ARB_IDLE   = 1'b0;
    localparam logic [0:0] ARB_LOCKED = 1'b1;

    // wr(1) + size(2) + wstrb(4) + addr(32) + wdata(32)
    localparam int REQ_FIELD_W = 71;

endpackage

// File: rtl/sram_req_arbiter_id.sv
// ----------------------------------------------------------------------------
// arb_id_fifo
// Synchronous FIFO holding the source ID of each accepted-but-not-returned
// transaction. Push and pop may occur in the same cycle (count unchanged,
// both pointers advance). Pushes while full and pops while empty are ignored.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (pointers and count only)
//   i_push   in   enqueue i_din
//   i_pop    in   dequeue head
//   i_din    in   ID to enqueue
//   o_head   out  ID at the head of the FIFO
//   o_full   out  count == DEPTH (registered count)
//   o_empty  out  count == 0
// ----------------------------------------------------------------------------
module arb_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// ----------------------------------------------------------------------------
// sram_req_arbiter
// Shares one sram-like memory port between the inst and data request
// channels. Requests are muxed combinationally (zero added latency); the
// source of every accepted request is queued so that responses, which return
// in order, are steered back to the channel that issued them.
//
// Optional build macro:
//   ARB_ROUND_ROBIN_EN  - defined: simultaneous inst/data requests in IDLE
//                         alternate, starting with data after reset.
//                         undefined: data channel always wins.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   inst_req/wr/size/wstrb/addr/wdata  inst request channel (in)
//   inst_addr_ok, inst_data_ok, inst_rdata  inst handshake/response (out)
//   data_req/wr/size/wstrb/addr/wdata  data request channel (in)
//   data_addr_ok, data_data_ok, data_rdata  data handshake/response (out)
//   mem_req/wr/size/wstrb/addr/wdata   downstream request (out)
//   mem_addr_ok, mem_data_ok, mem_rdata downstream handshake/response (in)
//   arb_err                         sticky: response with nothing outstanding
// ----------------------------------------------------------------------------
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTST_DEPTH = 4,
    parameter int ID_W        = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata,
    output logic        arb_err
);

    localparam logic [ID_W-1:0] ID_INST = ID_W'(SRC_INST);
    localparam logic [ID_W-1:0] ID_DATA = ID_W'(SRC_DATA);

    logic [0:0]             r_state;
    logic [ID_W-1:0]        r_grant_id;
    logic                   r_arb_err;
    logic [ID_W-1:0]        w_sel_id;
    logic [ID_W-1:0]        w_grant;
    logic [ID_W-1:0]        w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic [REQ_FIELD_W-1:0] w_inst_fields;
    logic [REQ_FIELD_W-1:0] w_data_fields;
    logic [REQ_FIELD_W-1:0] w_mem_fields;

`ifdef ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] r_last_grant;

    // On contention, pick the channel that did not win the previous accept.
    always_comb begin
        w_sel_id = ID_INST;
        if (data_req && inst_req) begin
            w_sel_id = (r_last_grant == ID_INST) ? ID_DATA : ID_INST;
        end else if (data_req) begin
            w_sel_id = ID_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= ID_INST;
        end else if (w_push) begin
            r_last_grant <= w_grant;
        end
    end
`else
    assign w_sel_id = data_req ? ID_DATA : ID_INST;
`endif

    // A stalled request keeps its channel locked onto the port until accepted.
    assign w_grant = (r_state == ARB_LOCKED) ? r_grant_id : w_sel_id;
    assign mem_req = (r_state == ARB_LOCKED) ? 1'b1
                   : (~w_full & (inst_req | data_req));

    assign w_inst_fields = {inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata};
    assign w_data_fields = {data_wr, data_size, data_wstrb, data_addr, data_wdata};
    assign w_mem_fields  = (w_grant == ID_DATA) ? w_data_fields : w_inst_fields;
    assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = w_mem_fields;

    assign w_push       = mem_req & mem_addr_ok;
    assign inst_addr_ok = w_push & (w_grant == ID_INST);
    assign data_addr_ok = w_push & (w_grant == ID_DATA);

    // Responses are steered by the oldest outstanding ID; rdata is shared.
    assign w_pop        = mem_data_ok & ~w_empty;
    assign inst_data_ok = w_pop & (w_head == ID_INST);
    assign data_data_ok = w_pop & (w_head == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign arb_err      = r_arb_err;

    arb_id_fifo #(
        .DEPTH (OUTST_DEPTH),
        .W     (ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_grant),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB_IDLE;
            r_grant_id <= ID_INST;
            r_arb_err  <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        r_state    <= ARB_LOCKED;
                        r_grant_id <= w_sel_id;
                    end
                end
                ARB_LOCKED: begin
                    if (mem_addr_ok) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
            if (mem_data_ok && w_empty) begin
                r_arb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic        arb_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.OUTST_DEPTH(4), .ID_W(1)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .arb_err(arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        tick(); tick();
        settle();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_arb_err", arb_err, 0);
        chk("rst_inst_aok", inst_addr_ok, 0);
        chk("rst_data_aok", data_addr_ok, 0);
        chk("rst_inst_dok", inst_data_ok, 0);
        chk("rst_data_dok", data_data_ok, 0);
        tick();
        reset = 1'b0;
        tick();

        // Both request together: data wins, inst follows next cycle.
        inst_req = 1; inst_addr = 32'h1c000000;
        data_req = 1; data_addr = 32'h00001000; data_wr = 1; data_wdata = 32'hdeadbeef;
        mem_addr_ok = 1;
        settle();
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'h00001000);
        chk("t1_mem_wr", mem_wr, 1);
        chk("t1_mem_wdata", mem_wdata, 32'hdeadbeef);
        chk("t1_data_aok", data_addr_ok, 1);
        chk("t1_inst_aok", inst_addr_ok, 0);
        tick();
        data_req = 0; data_wr = 0;
        settle();
        chk("t1_mem_addr2", mem_addr, 32'h1c000000);
        chk("t1_inst_aok2", inst_addr_ok, 1);
        chk("t1_data_aok2", data_addr_ok, 0);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'h11;
        settle();
        chk("t1_rsp1_data_dok", data_data_ok, 1);
        chk("t1_rsp1_inst_dok", inst_data_ok, 0);
        chk("t1_rsp1_rdata", data_rdata, 32'h11);
        tick();
        mem_rdata = 32'h22;
        settle();
        chk("t1_rsp2_inst_dok", inst_data_ok, 1);
        chk("t1_rsp2_data_dok", data_data_ok, 0);
        chk("t1_rsp2_rdata", inst_rdata, 32'h22);
        tick();
        mem_data_ok = 0;

        // Stalled data request locks the port while inst arrives.
        data_req = 1; data_addr = 32'h00002000;
        settle();
        chk("t2_c0_addr", mem_addr, 32'h00002000);
        chk("t2_c0_req", mem_req, 1);
        tick();
        inst_req = 1; inst_addr = 32'h1c000004;
        for (int c = 1; c <= 2; c++) begin
            settle();
            chk("t2_lock_addr", mem_addr, 32'h00002000);
            chk("t2_lock_inst_aok", inst_addr_ok, 0);
            chk("t2_lock_data_aok", data_addr_ok, 0);
            tick();
        end
        mem_addr_ok = 1;
        settle();
        chk("t2_acc_data_aok", data_addr_ok, 1);
        chk("t2_acc_inst_aok", inst_addr_ok, 0);
        chk("t2_acc_addr", mem_addr, 32'h00002000);
        tick();
        data_req = 0;
        settle();
        chk("t2_inst_addr", mem_addr, 32'h1c000004);
        chk("t2_inst_aok", inst_addr_ok, 1);
        tick();
        inst_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1;
        settle();
        chk("t2_rsp1_data_dok", data_data_ok, 1);
        tick();
        settle();
        chk("t2_rsp2_inst_dok", inst_data_ok, 1);
        tick();
        mem_data_ok = 0;

        // inst, data, inst accepted; responses routed in issue order.
        mem_addr_ok = 1;
        inst_req = 1;
        tick();
        inst_req = 0; data_req = 1;
        tick();
        data_req = 0; inst_req = 1;
        tick();
        inst_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'hA;
        settle();
        chk("t3_a_inst_dok", inst_data_ok, 1);
        chk("t3_a_data_dok", data_data_ok, 0);
        chk("t3_a_rdata", inst_rdata, 32'hA);
        tick();
        mem_rdata = 32'hB;
        settle();
        chk("t3_b_data_dok", data_data_ok, 1);
        chk("t3_b_inst_dok", inst_data_ok, 0);
        chk("t3_b_rdata", data_rdata, 32'hB);
        tick();
        mem_rdata = 32'hC;
        settle();
        chk("t3_c_inst_dok", inst_data_ok, 1);
        chk("t3_c_data_dok", data_data_ok, 0);
        chk("t3_c_rdata", inst_rdata, 32'hC);
        tick();
        mem_data_ok = 0;

        // Fill the FIFO with four inst accepts, then a fifth request stalls.
        mem_addr_ok = 1; inst_req = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t4_fill_aok", inst_addr_ok, 1);
            tick();
        end
        inst_req = 0; data_req = 1; data_addr = 32'h00003000;
        settle();
        chk("t4_full_req", mem_req, 0);
        chk("t4_full_aok", data_addr_ok, 0);
        tick();
        mem_data_ok = 1; mem_rdata = 32'h44;
        settle();
        chk("t4_pop_full_req", mem_req, 0);
        chk("t4_pop_inst_dok", inst_data_ok, 1);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t4_after_pop_req", mem_req, 1);
        chk("t4_after_pop_aok", data_addr_ok, 1);
        chk("t4_after_pop_addr", mem_addr, 32'h00003000);
        tick();
        data_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t4_drain_inst_dok", inst_data_ok, 1);
            tick();
        end
        settle();
        chk("t4_drain_data_dok", data_data_ok, 1);
        chk("t4_drain_inst_dok_last", inst_data_ok, 0);
        tick();

        // Response with nothing outstanding: dropped, sticky error.
        settle();
        chk("t5_empty_inst_dok", inst_data_ok, 0);
        chk("t5_empty_data_dok", data_data_ok, 0);
        tick();
        mem_data_ok = 0;
        settle();
        chk("t5_err_set", arb_err, 1);
        tick();
        settle();
        chk("t5_err_sticky", arb_err, 1);
        reset = 1;
        tick();
        reset = 0;
        settle();
        chk("t5_err_cleared", arb_err, 0);
        tick();

`ifdef ARB_ROUND_ROBIN_EN
        // Continuous contention alternates, data first after reset.
        inst_req = 1; data_req = 1; mem_addr_ok = 1;
        inst_addr = 32'h1c000000; data_addr = 32'h00001000;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("rr_data_aok", data_addr_ok, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_inst_aok", inst_addr_ok, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0;
        reset = 1;
        tick();
        reset = 0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
